// File: rtl/pool_unit_if.sv
// Handshake bundle for pool_unit: element stream in, pooled result stream out.
// Master is the producer/consumer side, slave is the pooling block.
interface pool_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1
);
    logic                         mode;
    logic                         clear;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data  [CHANNELS];
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data [CHANNELS];

    modport master (
        output mode, clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pool_unit.sv
// Per-lane max/average pooling over POOL_SIZE-element windows, result registered 1 cycle after last element.
// A held result stalls input until consumed; a consume and the next window's first element can share a cycle.
module pool_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int POOL_SIZE  = 4,
    parameter int CHANNELS   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    pool_unit_if.slave  bus
);
    localparam int CW = $clog2(POOL_SIZE);
    localparam int SW = DATA_WIDTH + CW;
    localparam logic [CW-1:0] LAST = CW'(POOL_SIZE - 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         mode_q, mode_d;
    logic                         out_vld_q, out_vld_d;
    logic signed [SW-1:0]         acc_q [CHANNELS];
    logic signed [SW-1:0]         acc_d [CHANNELS];
    logic signed [SW-1:0]         nxt   [CHANNELS];
    logic signed [SW-1:0]         xin   [CHANNELS];
    logic signed [DATA_WIDTH-1:0] res_q [CHANNELS];
    logic signed [DATA_WIDTH-1:0] res_d [CHANNELS];

    logic in_rdy;
    logic take;
    logic last;
    logic mode_eff;
    logic out_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (take && last) state_d = HOLD;
            HOLD:  if (bus.out_ready) state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_rdy        = (state_q == ACCUM) || bus.out_ready;
        bus.in_ready  = in_rdy;
        bus.out_valid = out_vld_q;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.out_data[i] = res_q[i];
        end
    end

    // An element accepted while clear is high is dropped, not just the window.
    always_comb begin
        take     = bus.in_valid && in_rdy && !bus.clear;
        last     = (cnt_q == LAST);
        mode_eff = (cnt_q == '0) ? bus.mode : mode_q;
        out_fire = out_vld_q && bus.out_ready;
        for (int i = 0; i < CHANNELS; i++) begin
            xin[i] = {{CW{bus.in_data[i][DATA_WIDTH-1]}}, bus.in_data[i]};
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        out_vld_d = out_vld_q;
        for (int i = 0; i < CHANNELS; i++) begin
            nxt[i]   = acc_q[i];
            acc_d[i] = acc_q[i];
            res_d[i] = res_q[i];
        end

        if (out_fire) out_vld_d = 1'b0;

        if (bus.clear) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d  = cnt_q + CW'(1);
            mode_d = mode_eff;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cnt_q == '0)
                    nxt[i] = xin[i];
                else if (mode_q)
                    nxt[i] = acc_q[i] + xin[i];
                else
                    nxt[i] = (xin[i] > acc_q[i]) ? xin[i] : acc_q[i];
                acc_d[i] = nxt[i];
                // Sum of POOL_SIZE elements shifted by CW always fits back in DATA_WIDTH.
                if (last)
                    res_d[i] = mode_eff ? DATA_WIDTH'(nxt[i] >>> CW) : nxt[i][DATA_WIDTH-1:0];
            end
            if (last) out_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            out_vld_q <= out_vld_d;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end
endmodule
